// File: rtl/multimode_ring_counter_pkg.sv
// Shared encodings for the multimode ring/Johnson counter.
package counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_LEFT     = 1'b0;
    localparam logic DIR_RIGHT    = 1'b1;

endpackage

// File: rtl/multimode_ring_counter_if.sv
// Control/status bundle between a sequencer client (master) and the counter (slave).
interface multimode_ring_counter_if #(
    parameter int N = 4
);
    localparam int PW = $clog2(2 * N);

    logic          en;
    logic          mode;
    logic          dir;
    logic          load;
    logic [N-1:0]  load_val;
    logic [N-1:0]  counter;
    logic [PW-1:0] pos;
    logic          wrap;
    logic          illegal;

    modport master (
        output en, mode, dir, load, load_val,
        input  counter, pos, wrap, illegal
    );

    modport slave (
        input  en, mode, dir, load, load_val,
        output counter, pos, wrap, illegal
    );

endinterface

// File: rtl/multimode_ring_counter_decode.sv
// Combinational legality check and position decode of a counter pattern.
module counter_state_decode
    import counter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(2 * N)
) (
    input  logic [N-1:0]  value,
    input  logic          mode,
    output logic          legal,
    output logic [PW-1:0] pos
);

    localparam logic [PW-1:0] ONE = PW'(1);

    logic [PW-1:0] ones;
    logic [PW-1:0] trans;
    logic [PW-1:0] idx;

    // Count set bits / adjacent transitions and find the set bit, then classify.
    always_comb begin
        ones  = '0;
        trans = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (value[i]) begin
                ones = ones + ONE;
                idx  = PW'(i);
            end
        end
        for (int i = 0; i < N - 1; i++) begin
            if (value[i] != value[i+1]) begin
                trans = trans + ONE;
            end
        end
        if (mode == MODE_RING) begin
            legal = (ones == ONE);
            pos   = idx;
        end else begin
            // A Johnson pattern has a single boundary between its 1-run and 0-run.
            legal = (trans <= ONE);
            if (value[0]) begin
                pos = ones;
            end else if (ones == '0) begin
                pos = '0;
            end else begin
                pos = PW'(2 * N) - ones;
            end
        end
    end

endmodule

// File: rtl/multimode_ring_counter.sv
// Ring / Johnson shift counter with direction, load, self-correction and wrap pulse.
module multimode_ring_counter
    import counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    multimode_ring_counter_if.slave   bus
);

    localparam int PW = $clog2(2 * N);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [N-1:0]  counter_q, counter_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          wrap_q, wrap_d;
    logic          illegal_q, illegal_d;
    logic          mode_q, mode_d;

    logic          cur_legal, load_legal;
    logic [PW-1:0] cur_pos, load_pos;
    logic [PW-1:0] last_pos;

    function automatic logic [N-1:0] seed(input logic m);
        return (m == MODE_JOHNSON) ? '0 : N'(1);
    endfunction

    function automatic logic [N-1:0] step(input logic [N-1:0] c, input logic m, input logic d);
        logic fb;
        if (d == DIR_LEFT) begin
            fb = (m == MODE_JOHNSON) ? ~c[N-1] : c[N-1];
            return {c[N-2:0], fb};
        end else begin
            fb = (m == MODE_JOHNSON) ? ~c[0] : c[0];
            return {fb, c[N-1:1]};
        end
    endfunction

    counter_state_decode #(.N(N), .PW(PW)) u_cur_decode (
        .value (counter_q),
        .mode  (mode_q),
        .legal (cur_legal),
        .pos   (cur_pos)
    );

    counter_state_decode #(.N(N), .PW(PW)) u_load_decode (
        .value (bus.load_val),
        .mode  (mode_q),
        .legal (load_legal),
        .pos   (load_pos)
    );

    assign last_pos = (mode_q == MODE_JOHNSON) ? PW'(2 * N - 1) : PW'(N - 1);

    // Next state: mode change > load > enable > hold.
    always_comb begin
        counter_d = counter_q;
        pos_d     = pos_q;
        wrap_d    = 1'b0;
        illegal_d = 1'b0;
        mode_d    = mode_q;
        if (bus.mode != mode_q) begin
            mode_d    = bus.mode;
            counter_d = seed(bus.mode);
            pos_d     = '0;
        end else if (bus.load) begin
            if (load_legal) begin
                counter_d = bus.load_val;
                pos_d     = load_pos;
            end else begin
                counter_d = seed(mode_q);
                pos_d     = '0;
                illegal_d = 1'b1;
            end
        end else if (bus.en) begin
            if (!cur_legal) begin
                counter_d = seed(mode_q);
                pos_d     = '0;
                illegal_d = 1'b1;
            end else begin
                counter_d = step(counter_q, mode_q, bus.dir);
                if (bus.dir == DIR_LEFT) begin
                    pos_d = (cur_pos == last_pos) ? '0 : cur_pos + ONE;
                end else begin
                    pos_d = (cur_pos == '0) ? last_pos : cur_pos - ONE;
                end
                wrap_d = (counter_d == seed(mode_q));
            end
        end
    end

    // State registers with synchronous active-low reset that seeds for the requested mode.
    always_ff @(posedge clk) begin
        if (!reset) begin
            counter_q <= seed(bus.mode);
            pos_q     <= '0;
            wrap_q    <= 1'b0;
            illegal_q <= 1'b0;
            mode_q    <= bus.mode;
        end else begin
            counter_q <= counter_d;
            pos_q     <= pos_d;
            wrap_q    <= wrap_d;
            illegal_q <= illegal_d;
            mode_q    <= mode_d;
        end
    end

    assign bus.counter = counter_q;
    assign bus.pos     = pos_q;
    assign bus.wrap    = wrap_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_multimode_ring_counter.sv
// Directed bench for multimode_ring_counter (N=4) with a position-based reference model.
module tb_multimode_ring_counter;

    localparam int N  = 4;
    localparam int PW = $clog2(2 * N);

    logic clk;
    logic reset;

    multimode_ring_counter_if #(.N(N)) bus ();

    multimode_ring_counter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the counter is represented only by its mode and step index.
    logic m_mode;
    int   m_pos;
    logic m_wrap;
    logic m_ill;

    function automatic logic [N-1:0] pat(input logic md, input int p);
        logic [N-1:0] ones;
        ones = '1;
        if (!md) return N'(1) << p;
        if (p <= N) return N'((1 << p) - 1);
        return ones << (p - N);
    endfunction

    function automatic int find_pos(input logic md, input logic [N-1:0] v);
        int per;
        per = md ? 2 * N : N;
        for (int p = 0; p < per; p++) begin
            if (pat(md, p) == v) return p;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the applied inputs, then compare every output.
    task automatic tick();
        int per;
        int lp;
        per = m_mode ? 2 * N : N;
        if (!reset) begin
            m_mode = bus.mode; m_pos = 0; m_wrap = 1'b0; m_ill = 1'b0;
        end else if (bus.mode != m_mode) begin
            m_mode = bus.mode; m_pos = 0; m_wrap = 1'b0; m_ill = 1'b0;
        end else if (bus.load) begin
            lp = find_pos(m_mode, bus.load_val);
            m_wrap = 1'b0;
            if (lp < 0) begin
                m_pos = 0; m_ill = 1'b1;
            end else begin
                m_pos = lp; m_ill = 1'b0;
            end
        end else if (bus.en) begin
            m_pos  = bus.dir ? (m_pos + per - 1) % per : (m_pos + 1) % per;
            m_wrap = (m_pos == 0);
            m_ill  = 1'b0;
        end else begin
            m_wrap = 1'b0; m_ill = 1'b0;
        end
        @(posedge clk);
        #1;
        check("model_counter", int'(bus.counter), int'(pat(m_mode, m_pos)));
        check("model_pos", int'(bus.pos), m_pos);
        check("model_wrap", int'(bus.wrap), int'(m_wrap));
        check("model_illegal", int'(bus.illegal), int'(m_ill));
    endtask

    // Hand-computed literal expectations.
    task automatic lit(input string name, input logic [N-1:0] c, input int p, input logic w, input logic il);
        check({name, "_counter"}, int'(bus.counter), int'(c));
        check({name, "_pos"}, int'(bus.pos), p);
        check({name, "_wrap"}, int'(bus.wrap), int'(w));
        check({name, "_illegal"}, int'(bus.illegal), int'(il));
    endtask

    logic [N-1:0] ring_seq [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [N-1:0] john_seq [8]  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};

    initial begin
        m_mode = 1'b0; m_pos = 0; m_wrap = 1'b0; m_ill = 1'b0;
        reset = 1'b0;
        bus.en = 1'b0; bus.mode = 1'b0; bus.dir = 1'b0; bus.load = 1'b0; bus.load_val = '0;

        // Reset and ring left
        tick(); tick();
        lit("reset", 4'b0001, 0, 1'b0, 1'b0);
        reset = 1'b1; bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit("ring_left", ring_seq[i], (i + 1) % 4, (i == 3), 1'b0);
        end

        // Johnson left over a full period
        bus.mode = 1'b1;
        tick();
        lit("to_johnson", 4'b0000, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            lit("john_left", john_seq[i], (i + 1) % 8, (i == 7), 1'b0);
        end

        // Ring right then hold
        bus.mode = 1'b0;
        tick();
        lit("to_ring", 4'b0001, 0, 1'b0, 1'b0);
        bus.dir = 1'b1;
        tick();
        lit("ring_right1", 4'b1000, 3, 1'b0, 1'b0);
        tick();
        lit("ring_right2", 4'b0100, 2, 1'b0, 1'b0);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit("hold", 4'b0100, 2, 1'b0, 1'b0);
        end

        // Loads
        bus.load = 1'b1; bus.load_val = 4'b0110;
        tick();
        lit("ring_load_bad", 4'b0001, 0, 1'b0, 1'b1);
        bus.load_val = 4'b0100;
        tick();
        lit("ring_load_ok", 4'b0100, 2, 1'b0, 1'b0);
        bus.mode = 1'b1;
        tick();
        lit("load_mode_chg", 4'b0000, 0, 1'b0, 1'b0);
        bus.load_val = 4'b0101;
        tick();
        lit("john_load_bad", 4'b0000, 0, 1'b0, 1'b1);
        bus.load_val = 4'b1100;
        tick();
        lit("john_load_ok", 4'b1100, 6, 1'b0, 1'b0);
        bus.load = 1'b0;

        // Mode change while running
        bus.mode = 1'b0; bus.en = 1'b1; bus.dir = 1'b0;
        tick(); tick(); tick();
        lit("ring_run", 4'b0100, 2, 1'b0, 1'b0);
        bus.mode = 1'b1;
        tick();
        lit("run_mode_chg", 4'b0000, 0, 1'b0, 1'b0);

        // Reset beats load and enable
        tick(); tick(); tick();
        lit("john_0111", 4'b0111, 3, 1'b0, 1'b0);
        bus.load = 1'b1; bus.load_val = 4'b0011; reset = 1'b0;
        tick();
        lit("reset_wins", 4'b0000, 0, 1'b0, 1'b0);
        reset = 1'b1; bus.load = 1'b0;

        // Johnson right wraps backwards, then dir flips back onto the seed
        bus.dir = 1'b1;
        tick();
        lit("john_right", 4'b1000, 7, 1'b0, 1'b0);
        bus.dir = 1'b0;
        tick();
        lit("john_back", 4'b0000, 0, 1'b1, 1'b0);
        bus.dir = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
